// File: rtl/gemcsc_match_pkg.sv
// gemcsc_match_pkg
// Shared definitions for the GEM-CSC match window:
//   - HS_W / WG_W : half-strip and wiregroup field widths
//   - state_t     : search state machine encoding (IDLE, SEARCH, DONE)
//   - gem_entry_t : one bx worth of GEM copad + single-cluster data
//   - abs_diff_hs : |a - b| on half-strip fields, computed one bit wider
//                   so the subtraction cannot wrap
package gemcsc_match_pkg;

    localparam int HS_W = 8;
    localparam int WG_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic            copad_vld;
        logic [HS_W-1:0] copad_hs;
        logic [WG_W-1:0] copad_wg;
        logic            gem_vld;
        logic [HS_W-1:0] gem_hs;
        logic [WG_W-1:0] gem_wg;
    } gem_entry_t;

    function automatic logic [HS_W:0] abs_diff_hs(input logic [HS_W-1:0] a,
                                                  input logic [HS_W-1:0] b);
        logic [HS_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[HS_W]) begin
            return (~d) + (HS_W+1)'(1);
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/gemcsc_absdiff_cmp.sv
// gemcsc_absdiff_cmp
// Spatial window comparator: hit = |a - b| <= LIMIT.
// Both operands are zero-extended by one bit before subtracting, so the
// difference is a true signed value and never wraps around.
// Ports:
//   a, b : W-bit unsigned positions
//   hit  : 1 when the positions are within LIMIT of each other
module gemcsc_absdiff_cmp #(
    parameter int W     = 8,
    parameter int LIMIT = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         hit
);

    logic [W:0] diff_s;
    logic [W:0] mag_s;

    // signed difference, its magnitude and the window test
    always_comb begin
        diff_s = {1'b0, a} - {1'b0, b};
        if (diff_s[W]) begin
            mag_s = (~diff_s) + (W+1)'(1);
        end else begin
            mag_s = diff_s;
        end
        hit = (mag_s <= (W+1)'(LIMIT));
    end

endmodule

// File: rtl/gemcsc_match_window.sv
// gemcsc_match_window
// Buffers GEM copad / cluster hits over the last MXWIN bx, snapshots the
// window when a CLCT and/or ALCT arrives, scans one entry per clock and
// publishes registered match flags plus the bend-enable bit.
// Ports:
//   clock, reset               : 40 MHz clock, synchronous active-high reset
//   copad_* / gem_*            : GEM copad and single-cluster hits this bx
//   clct_* / alct_*            : CSC trigger primitives this bx
//   cfg_bend_en                : global bend correction enable
//   busy                       : search in progress, triggers refused
//   result_vld                 : one-cycle strobe, flags valid
//   *_match, gemcsc_bend_enable: match results, held until next trigger
//   drop_cnt                   : saturating count of refused triggers
// Configuration macro: GEMCSC_DROP_COUNTER_EN enables drop_cnt; without it
// drop_cnt reads 0 and refused triggers are discarded silently.
module gemcsc_match_window
    import gemcsc_match_pkg::*;
#(
    parameter int MXWIN      = 4,
    parameter int HS_DELTA   = 4,
    parameter int WG_DELTA   = 3,
    parameter int BEND_DELTA = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            copad_vld,
    input  logic [HS_W-1:0] copad_hs,
    input  logic [WG_W-1:0] copad_wg,
    input  logic            gem_vld,
    input  logic [HS_W-1:0] gem_hs,
    input  logic [WG_W-1:0] gem_wg,
    input  logic            clct_vld,
    input  logic [HS_W-1:0] clct_hs,
    input  logic            alct_vld,
    input  logic [WG_W-1:0] alct_wg,
    input  logic            cfg_bend_en,
    output logic            busy,
    output logic            result_vld,
    output logic            alct_clct_copad_match,
    output logic            alct_clct_gem_match,
    output logic            alct_clct_match,
    output logic            clct_copad_match,
    output logic            alct_copad_match,
    output logic            gemcsc_bend_enable,
    output logic [7:0]      drop_cnt
);

    // a 1-deep window still needs a legal (unused) buffer declaration
    localparam int BUF_D = (MXWIN > 1) ? MXWIN - 1 : 1;
    localparam int IDX_W = (MXWIN > 1) ? $clog2(MXWIN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MXWIN - 1);

    gem_entry_t      in_s;
    gem_entry_t      cur_s;
    gem_entry_t      hist_r [BUF_D];
    gem_entry_t      snap_r [MXWIN];
    state_t          state_r, state_s;
    logic [IDX_W-1:0] idx_r;
    logic            trig_s, accept_s, busy_s, done_s;
    logic            clct_vld_r, alct_vld_r;
    logic [HS_W-1:0] clct_hs_r;
    logic [WG_W-1:0] alct_wg_r;
    logic            chs_hit_s, cwg_hit_s, ghs_hit_s, gwg_hit_s;
    logic            chs_s, cwg_s, ghs_s, gwg_s, cpd_both_s, gem_both_s;
    logic [HS_W:0]   bend_mag_s;
    logic            bend_ok_s;
    logic            acc_cc_r, acc_ac_r, acc_acc_r, acc_acg_r, found_r, bend_ok_r;
    logic            busy_r, result_vld_r, acc_out_r, acg_out_r, ac_out_r;
    logic            cc_out_r, aco_out_r, bend_out_r;

    // pack the live GEM inputs into one entry record
    always_comb begin
        in_s.copad_vld = copad_vld;
        in_s.copad_hs  = copad_hs;
        in_s.copad_wg  = copad_wg;
        in_s.gem_vld   = gem_vld;
        in_s.gem_hs    = gem_hs;
        in_s.gem_wg    = gem_wg;
    end

    assign trig_s   = clct_vld | alct_vld;
    assign accept_s = trig_s & (state_r == IDLE);

    // history shift register, runs every clock including during a search
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BUF_D; i++) hist_r[i] <= '0;
        end else begin
            hist_r[0] <= in_s;
            for (int i = 1; i < BUF_D; i++) hist_r[i] <= hist_r[i-1];
        end
    end

    // state register and scan index
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == SEARCH) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= '0;
            end
        end
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (trig_s) state_s = SEARCH; else state_s = IDLE;
            SEARCH:  if (idx_r == IDX_LAST) state_s = DONE; else state_s = SEARCH;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // state-decoded controls; registered below, hence the one-edge lag
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
            SEARCH:  begin busy_s = 1'b1; done_s = 1'b0; end
            DONE:    begin busy_s = 1'b1; done_s = 1'b1; end
            default: begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // snapshot of the GEM window and the CSC trigger fields
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < MXWIN; k++) snap_r[k] <= '0;
            clct_vld_r <= 1'b0;
            alct_vld_r <= 1'b0;
            clct_hs_r  <= '0;
            alct_wg_r  <= '0;
        end else if (accept_s) begin
            snap_r[0] <= in_s;
            for (int k = 1; k < MXWIN; k++) snap_r[k] <= hist_r[k-1];
            clct_vld_r <= clct_vld;
            alct_vld_r <= alct_vld;
            clct_hs_r  <= clct_hs;
            alct_wg_r  <= alct_wg;
        end else begin
            clct_vld_r <= clct_vld_r;
            alct_vld_r <= alct_vld_r;
        end
    end

    assign cur_s = snap_r[idx_r];

    gemcsc_absdiff_cmp #(.W(HS_W), .LIMIT(HS_DELTA)) u_chs (
        .a(cur_s.copad_hs), .b(clct_hs_r), .hit(chs_hit_s));
    gemcsc_absdiff_cmp #(.W(WG_W), .LIMIT(WG_DELTA)) u_cwg (
        .a(cur_s.copad_wg), .b(alct_wg_r), .hit(cwg_hit_s));
    gemcsc_absdiff_cmp #(.W(HS_W), .LIMIT(HS_DELTA)) u_ghs (
        .a(cur_s.gem_hs),   .b(clct_hs_r), .hit(ghs_hit_s));
    gemcsc_absdiff_cmp #(.W(WG_W), .LIMIT(WG_DELTA)) u_gwg (
        .a(cur_s.gem_wg),   .b(alct_wg_r), .hit(gwg_hit_s));

    // qualify spatial hits with entry and CSC valids; pick bend source
    always_comb begin
        chs_s      = chs_hit_s & cur_s.copad_vld & clct_vld_r;
        cwg_s      = cwg_hit_s & cur_s.copad_vld & alct_vld_r;
        ghs_s      = ghs_hit_s & cur_s.gem_vld   & clct_vld_r;
        gwg_s      = gwg_hit_s & cur_s.gem_vld   & alct_vld_r;
        cpd_both_s = chs_s & cwg_s;
        gem_both_s = ghs_s & gwg_s;
        // copad outranks a cluster in the same entry
        if (cpd_both_s) begin
            bend_mag_s = abs_diff_hs(cur_s.copad_hs, clct_hs_r);
        end else begin
            bend_mag_s = abs_diff_hs(cur_s.gem_hs, clct_hs_r);
        end
        bend_ok_s = (bend_mag_s <= (HS_W+1)'(BEND_DELTA));
    end

    // sticky accumulators and lowest-k both-match selection
    always_ff @(posedge clock) begin
        if (reset || accept_s) begin
            acc_cc_r  <= 1'b0;
            acc_ac_r  <= 1'b0;
            acc_acc_r <= 1'b0;
            acc_acg_r <= 1'b0;
            found_r   <= 1'b0;
            bend_ok_r <= 1'b0;
        end else if (state_r == SEARCH) begin
            acc_cc_r  <= acc_cc_r  | chs_s;
            acc_ac_r  <= acc_ac_r  | cwg_s;
            acc_acc_r <= acc_acc_r | cpd_both_s;
            acc_acg_r <= acc_acg_r | gem_both_s;
            if (!found_r && (cpd_both_s || gem_both_s)) begin
                found_r   <= 1'b1;
                bend_ok_r <= bend_ok_s;
            end else begin
                found_r   <= found_r;
                bend_ok_r <= bend_ok_r;
            end
        end else begin
            acc_cc_r <= acc_cc_r;
        end
    end

    // registered outputs: published on DONE, held until the next trigger
    always_ff @(posedge clock) begin
        if (reset || accept_s) begin
            busy_r       <= 1'b0;
            result_vld_r <= 1'b0;
            acc_out_r    <= 1'b0;
            acg_out_r    <= 1'b0;
            ac_out_r     <= 1'b0;
            cc_out_r     <= 1'b0;
            aco_out_r    <= 1'b0;
            bend_out_r   <= 1'b0;
        end else begin
            busy_r       <= busy_s;
            result_vld_r <= done_s;
            if (done_s) begin
                acc_out_r  <= acc_acc_r;
                acg_out_r  <= acc_acg_r;
                ac_out_r   <= alct_vld_r & clct_vld_r;
                cc_out_r   <= acc_cc_r;
                aco_out_r  <= acc_ac_r;
                bend_out_r <= cfg_bend_en & found_r & bend_ok_r;
            end else begin
                acc_out_r  <= acc_out_r;
            end
        end
    end

    assign busy                  = busy_r;
    assign result_vld            = result_vld_r;
    assign alct_clct_copad_match = acc_out_r;
    assign alct_clct_gem_match   = acg_out_r;
    assign alct_clct_match       = ac_out_r;
    assign clct_copad_match      = cc_out_r;
    assign alct_copad_match      = aco_out_r;
    assign gemcsc_bend_enable    = bend_out_r;

`ifdef GEMCSC_DROP_COUNTER_EN
    logic       refuse_s;
    logic [7:0] drop_cnt_r;

    assign refuse_s = trig_s & (state_r != IDLE);

    // saturating refused-trigger counter
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_r <= 8'd0;
        end else if (refuse_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
